// File: rtl/sync_wait_merge_ctrl_if.sv
// Handshake bundle between the producer lanes, the join controller and the
// downstream consumer.
//   i_drive     per-lane one-cycle drive pulse (producer -> controller)
//   i_data      lane data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_free      per-lane one-cycle free pulse (controller -> producers)
//   o_driveNext one-cycle merged drive pulse (controller -> consumer)
//   o_data      merged data, same lane packing as i_data
//   i_freeNext  one-cycle free pulse (consumer -> controller)
// master = the environment driving producers/consumer, slave = the controller.
interface sync_wait_merge_ctrl_if #(
    parameter int NUM_IN     = 9,
    parameter int DATA_WIDTH = 3
);
    logic [NUM_IN-1:0]            i_drive;
    logic [NUM_IN*DATA_WIDTH-1:0] i_data;
    logic                         i_freeNext;
    logic [NUM_IN-1:0]            o_free;
    logic                         o_driveNext;
    logic [NUM_IN*DATA_WIDTH-1:0] o_data;

    modport master (
        output i_drive, i_data, i_freeNext,
        input  o_free, o_driveNext, o_data
    );

    modport slave (
        input  i_drive, i_data, i_freeNext,
        output o_free, o_driveNext, o_data
    );
endinterface

// File: rtl/sync_wait_merge_ctrl.sv
// N-way synchronous wait-merge (join) controller.
// Collects one drive pulse plus data from every enabled lane, fires a single
// merged drive, holds the merged data until the consumer frees it, then
// broadcasts free to the enabled lanes. Also reports protocol errors, an
// arrival timeout with the set of missing lanes, and counts fired merges.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   i_cfg_mask      lane enable, sampled only while idle
//   i_timeout_lim   arrival timeout in cycles, 0 disables
//   i_clr_err       clears o_err / o_timeout / o_missing
//   bus             handshake bundle (drive/data/free in both directions)
//   o_busy          a collection is in progress or waiting for free
//   o_timeout       sticky timeout flag, o_missing = lanes absent at timeout
//   o_err           sticky protocol-error flag
//   o_merge_cnt     number of completed merges, wraps
// All outputs are registered.
module sync_wait_merge_ctrl #(
    parameter int NUM_IN     = 9,
    parameter int DATA_WIDTH = 3,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IN-1:0]    i_cfg_mask,
    input  logic [TIMEOUT_W-1:0] i_timeout_lim,
    input  logic                 i_clr_err,
    sync_wait_merge_ctrl_if.slave bus,
    output logic                 o_busy,
    output logic                 o_timeout,
    output logic [NUM_IN-1:0]    o_missing,
    output logic                 o_err,
    output logic [15:0]          o_merge_cnt
);
    localparam int DW_ALL = NUM_IN * DATA_WIDTH;

    typedef enum logic {COLLECT, WAIT_FREE} state_t;

    state_t               state_q, state_d;
    logic [NUM_IN-1:0]    arrived_q, arrived_d, arrived_nx, accept;
    logic [NUM_IN-1:0]    mask_q, mask_d;
    logic [DW_ALL-1:0]    data_q, data_d, odata_q, odata_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
    logic [NUM_IN-1:0]    free_q, free_d, missing_q, missing_d;
    logic                 drive_next_q, drive_next_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d, err_q, err_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 err_set, fire, tmo_evt;

    // NOTE: every signal written here gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        arrived_d    = arrived_q;
        arrived_nx   = arrived_q;
        accept       = '0;
        mask_d       = mask_q;
        data_d       = data_q;
        free_d       = '0;
        drive_next_d = 1'b0;
        cnt_d        = cnt_q;
        tcnt_d       = '0;
        err_set      = 1'b0;
        fire         = 1'b0;

        // The mask only changes between collections, never mid-join.
        if (state_q == COLLECT && arrived_q == '0 && bus.i_drive == '0)
            mask_d = i_cfg_mask;

        case (state_q)
            COLLECT: begin
                accept     = bus.i_drive & mask_q & ~arrived_q;
                // An all-zero mask makes the controller inert: stray drives
                // are not treated as errors.
                err_set    = (|(bus.i_drive & arrived_q))
                           | ((mask_q != '0) & (|(bus.i_drive & ~mask_q)))
                           | bus.i_freeNext;
                arrived_nx = arrived_q | accept;
                arrived_d  = arrived_nx;
                for (int i = 0; i < NUM_IN; i++)
                    if (accept[i])
                        data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.i_data[i*DATA_WIDTH +: DATA_WIDTH];
                fire = (mask_q != '0) && (&(arrived_nx | ~mask_q));
                if (fire) begin
                    drive_next_d = 1'b1;
                    state_d      = WAIT_FREE;
                end else if (arrived_nx != '0) begin
                    // Counts cycles since the first arrival; saturates.
                    tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + TIMEOUT_W'(1);
                end
            end
            WAIT_FREE: begin
                err_set = |bus.i_drive;
                if (bus.i_freeNext) begin
                    free_d    = mask_q;
                    arrived_d = '0;
                    state_d   = COLLECT;
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            default: state_d = COLLECT;
        endcase

        // Fires only on the step into the limit, so a saturated counter
        // parked at the limit cannot re-capture o_missing.
        tmo_evt = (i_timeout_lim != '0) && (tcnt_d == i_timeout_lim) && (tcnt_q != i_timeout_lim);

        // Set events take priority over the clear request.
        err_d     = err_set ? 1'b1 : (i_clr_err ? 1'b0 : err_q);
        timeout_d = tmo_evt ? 1'b1 : (i_clr_err ? 1'b0 : timeout_q);
        missing_d = tmo_evt ? (mask_q & ~arrived_nx) : (i_clr_err ? '0 : missing_q);

        // Masked lanes read as zero even if their register holds stale data.
        odata_d = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (mask_d[i])
                odata_d[i*DATA_WIDTH +: DATA_WIDTH] = data_d[i*DATA_WIDTH +: DATA_WIDTH];

        busy_d = (arrived_d != '0) || (state_d == WAIT_FREE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // NOTE: the lane data registers are reset like the control state; they
    // are small flop arrays, not RAM, and this keeps o_data at 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COLLECT;
            arrived_q    <= '0;
            mask_q       <= '0;
            data_q       <= '0;
            odata_q      <= '0;
            tcnt_q       <= '0;
            free_q       <= '0;
            drive_next_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            missing_q    <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            arrived_q    <= arrived_d;
            mask_q       <= mask_d;
            data_q       <= data_d;
            odata_q      <= odata_d;
            tcnt_q       <= tcnt_d;
            free_q       <= free_d;
            drive_next_q <= drive_next_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            missing_q    <= missing_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.o_free      = free_q;
    assign bus.o_driveNext = drive_next_q;
    assign bus.o_data      = odata_q;
    assign o_busy          = busy_q;
    assign o_timeout       = timeout_q;
    assign o_missing       = missing_q;
    assign o_err           = err_q;
    assign o_merge_cnt     = cnt_q;
endmodule
